clk_sel_scheduler: RTL

CLK_SEL_SCHEDULER -- requirements
Module: clk_sel_scheduler

---
 rtl/clk_sel_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clk_sel_scheduler.sv
// rtl/clk_sel_scheduler.sv - divided-clock select scheduler; define CLK_SCHED_FIXED_PRIO_EN for fixed priority arbitration
module clk_sel_scheduler #(
   parameter int HOLD_W = 8,
   parameter int NREQ   = 4
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                en,
   input  logic [31:0]         cnt,
   input  logic [NREQ-1:0]     req,
   input  logic [5*NREQ-1:0]   req_sel,
   input  logic [HOLD_W-1:0]   hold_ticks,
   output logic [4:0]          sel,
   output logic [NREQ-1:0]     gnt,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SWITCH  = 2'd1,
      S_RUN     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          sel_q, sel_d;
   logic [4:0]          tgt_q, tgt_d;
   logic [1:0]          idx_q, idx_d;
   logic [HOLD_W-1:0]   left_q, left_d;
   logic                hist_q, hist_d;
`ifndef CLK_SCHED_FIXED_PRIO_EN
   logic [1:0]          last_q, last_d;
`endif

   logic [4:0]          sel_arr [NREQ];
   logic [1:0]          win_idx;
   logic                win_found;
   logic [4:0]          win_tgt;
   logic [4:0]          max_sel;
   logic [31:0]         low_mask;
   logic                safe_pt;
   logic                cur_bit;

   // unpack the per-requester select fields
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         sel_arr[k] = req_sel[5*k +: 5];
      end
   end

   // winner search: fixed priority from 0, or round-robin starting after the last grant
   always_comb begin
      logic [1:0] cand;
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef CLK_SCHED_FIXED_PRIO_EN
         cand = 2'(k);
`else
         cand = last_q + 2'(k + 1);
`endif
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_tgt  = sel_arr[win_idx];
   assign max_sel  = (sel_q > tgt_q) ? sel_q : tgt_q;
   assign low_mask = 32'hFFFF_FFFF >> (5'd31 - max_sel);
   assign safe_pt  = en && ((cnt & low_mask) == low_mask);
   assign cur_bit  = cnt[sel_q];

   // state and datapath registers
   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sel_q   <= 5'd0;
         tgt_q   <= 5'd0;
         idx_q   <= 2'd0;
         left_q  <= '0;
         hist_q  <= 1'b0;
`ifndef CLK_SCHED_FIXED_PRIO_EN
         last_q  <= 2'd3;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tgt_q   <= tgt_d;
         idx_q   <= idx_d;
         left_q  <= left_d;
         hist_q  <= hist_d;
`ifndef CLK_SCHED_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   // next-state logic; a dropped request aborts regardless of en
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tgt_d   = tgt_q;
      idx_d   = idx_q;
      left_d  = left_q;
      hist_d  = hist_q;
`ifndef CLK_SCHED_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (en && win_found) begin
               idx_d   = win_idx;
               tgt_d   = win_tgt;
               left_d  = (hold_ticks == '0) ? HOLD_W'(1) : hold_ticks;
               hist_d  = cnt[win_tgt];
               state_d = (win_tgt == sel_q) ? S_RUN : S_SWITCH;
            end
         end
         S_SWITCH: begin
            if (!req[idx_q]) begin
               state_d = S_RELEASE;
            end else if (safe_pt) begin
               sel_d   = tgt_q;
               hist_d  = cnt[tgt_q];
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!req[idx_q]) begin
               state_d = S_RELEASE;
            end else if (en) begin
               hist_d = cur_bit;
               if (cur_bit && !hist_q) begin
                  left_d = left_q - HOLD_W'(1);
                  if (left_q == HOLD_W'(1)) begin
                     state_d = S_RELEASE;
                  end
               end
            end
         end
         S_RELEASE: begin
`ifndef CLK_SCHED_FIXED_PRIO_EN
            last_d  = idx_q;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // grant decode: live only while switching or running
   always_comb begin
      gnt = '0;
      if (state_q == S_SWITCH || state_q == S_RUN) begin
         gnt[idx_q] = 1'b1;
      end
   end

   assign sel  = sel_q;
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_RELEASE);

endmodule
